instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001: The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-002: The block SHALL have parameter RESET_PC, default 0, giving the first fetch address; it SHALL be a multiple of 4.
REQ-003: The block SHALL have one clock; reset is asynchronous and active-high. Port names are clk and reset.
REQ-004: clk  input  1  rising-edge clock for all state.
REQ-005: reset  input  1  asynchronous active-high reset.
REQ-006: fetch_en  input  1  permits starting a new instruction fetch.
REQ-007: mem_rd  output  1  byte read request to instruction memory.
REQ-008: mem_addr  output  ADDR_W  byte address of the current read request.
REQ-009: mem_data  input  8  read byte, valid in the cycle after the matching mem_rd (fixed 1-cycle latency).
REQ-010: instr_out  output  32  assembled instruction word.
REQ-011: instr_pc  output  ADDR_W  byte address of byte 0 of instr_out.
REQ-012: instr_valid  output  1  instr_out and instr_pc hold a complete instruction.
REQ-013: instr_ready  input  1  downstream decode accepts the instruction.
REQ-014: pc_load  input  1  redirect request (branch or jump).
REQ-015: pc_load_addr  input  ADDR_W  redirect target.

Function
REQ-016: The FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-017: In IDLE with fetch_en=1, the next edge SHALL enter FETCH with byte_cnt=0.
REQ-018: In IDLE with fetch_en=0, the block SHALL remain in IDLE.
REQ-019: FETCH SHALL drive mem_rd=1 for exactly 4 consecutive cycles, with mem_addr = pc+byte_cnt and byte_cnt = 0,1,2,3.
REQ-020: A registered rd_pending flag SHALL mark that mem_data is to be captured at the next edge.
REQ-021: Byte k SHALL be written into instr_out[8k+7:8k] (little-endian), so the word is built by shifting each new byte in at bits [31:24].
REQ-022: After the 4th byte is captured, the next edge SHALL enter HOLD with instr_valid=1 and instr_pc=pc.
REQ-023: Latency from the first mem_rd cycle to instr_valid=1 SHALL be 5 cycles; mem_rd SHALL be 0 outside FETCH.
REQ-024: In HOLD, instr_out, instr_pc and instr_valid SHALL stay stable until instr_valid & instr_ready at an edge.
REQ-025: On that handshake, pc SHALL become pc+4 modulo 2^ADDR_W and instr_valid SHALL drop.
REQ-026: After the handshake, the FSM SHALL go to FETCH if fetch_en=1, else to IDLE.
REQ-027: Deasserting fetch_en in FETCH SHALL NOT abort the fetch in progress.
REQ-028: pc_load=1 at any edge in any state SHALL set pc = {pc_load_addr[ADDR_W-1:2], 2'b00}.
REQ-029: On that same pc_load edge, the block SHALL clear byte_cnt, rd_pending and instr_valid, and discard any partially assembled bytes.
REQ-030: After a pc_load, the FSM SHALL enter FETCH if fetch_en=1, else IDLE.
REQ-031: pc_load together with a HOLD handshake SHALL complete the handshake (instruction consumed) and load pc_load_addr, not pc+4.
REQ-032: pc_load SHALL NOT be accepted as a handshake; instr_valid is 0 in the cycle after pc_load.
REQ-033: A late mem_data byte belonging to a request issued before pc_load SHALL be ignored.
REQ-034: PC wrap-around SHALL be defined: pc = 2^ADDR_W-4 increments to 0, and byte addresses in FETCH wrap the same way.

Reset
REQ-035: While reset=1, all state SHALL clear immediately, independent of clk.
REQ-036: Reset values SHALL be: FSM=IDLE, pc=RESET_PC, byte_cnt=0, rd_pending=0, mem_rd=0, mem_addr=RESET_PC, instr_out=0, instr_pc=RESET_PC, instr_valid=0.
REQ-037: Reset asserted mid-FETCH or mid-HOLD SHALL abandon the instruction; the first fetch after release starts at RESET_PC.

Verification
REQ-038: Basic fetch: RESET_PC=0, fetch_en=1, instr_ready=1, memory bytes 0x13,0x00,0x50,0x00 -> mem_addr 0,1,2,3 over 4 cycles; instr_valid in cycle 5 with instr_out=0x00500013, instr_pc=0; next fetch at 4.
REQ-039: Backpressure: instr_ready=0 for 10 cycles in HOLD -> instr_out, instr_pc and instr_valid stable, mem_rd=0; ready=1 -> pc=4.
REQ-040: Redirect mid-fetch: pc_load=1 with pc_load_addr=0x103 after 2 bytes -> old bytes dropped, next mem_addr=0x100, instr_pc=0x100.
REQ-041: Simultaneous handshake and pc_load to 0x40 -> the instruction is consumed once and the next fetch is at 0x40.
REQ-042: Wrap: ADDR_W=8, pc=0xFC -> byte addresses 0xFC..0xFF, then the next instr_pc=0x00.
REQ-043: Asynchronous reset asserted mid-FETCH between edges -> outputs reach reset values before the next edge; after release the first fetch starts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Fetches 32-bit instructions from a byte-wide instruction memory. Each
//   instruction takes four back-to-back byte reads at pc+0..pc+3. The bytes
//   are assembled little-endian into a word, and that word is presented to
//   decode with a valid/ready handshake. A redirect (pc_load) can arrive at
//   any edge. It discards any work in progress and restarts fetching at the
//   word-aligned target.
//
// Parameters:
//   ADDR_W   - byte-address width
//   RESET_PC - first fetch address (word aligned)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   fetch_en     in   permits starting a new instruction fetch
//   mem_rd       out  byte read request
//   mem_addr     out  byte address of the current read request
//   mem_data     in   read byte, valid one cycle after its mem_rd
//   instr_out    out  assembled instruction word
//   instr_pc     out  address of byte 0 of instr_out
//   instr_valid  out  instr_out / instr_pc hold a complete instruction
//   instr_ready  in   decode accepts the instruction
//   pc_load      in   redirect request
//   pc_load_addr in   redirect target (low two bits ignored)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Force word alignment of the reset address so that a misconfigured
  // parameter can never produce an unaligned fetch.
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [1:0]        byte_cnt_reg;     // index of the byte being requested
  logic              rd_pending_reg;   // mem_data is to be captured at the next edge
  logic              mem_rd_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       asm_reg;          // partially assembled word
  logic [31:0]       instr_out_reg;
  logic [ADDR_W-1:0] instr_pc_reg;
  logic              instr_valid_reg;

  logic              handshake;
  logic [ADDR_W-1:0] load_pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_byte_addr;
  logic [31:0]       asm_next;
  logic              unused_load_bits;

  assign handshake = (state_reg == HOLD) && instr_valid_reg && instr_ready;
  assign load_pc   = {pc_load_addr[ADDR_W-1:2], 2'b00};
  assign pc_plus4  = pc_reg + ADDR_W'(4);

  // Address of the byte after the one requested this cycle. It is a plain
  // ADDR_W-wide add, so fetches that straddle the top of the address space
  // wrap to zero in the same way as the pc.
  assign next_byte_addr = pc_reg + ADDR_W'(byte_cnt_reg) + ADDR_W'(1);

  // Each new byte enters at the top and older bytes shift down. After four
  // captures, byte 0 therefore ends up in bits [7:0] (little-endian).
  assign asm_next = {mem_data, asm_reg[31:8]};

  // The alignment bits of the redirect target are intentionally dropped.
  assign unused_load_bits = &{1'b0, pc_load_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC_ALIGNED;
      byte_cnt_reg    <= 2'd0;
      rd_pending_reg  <= 1'b0;
      mem_rd_reg      <= 1'b0;
      mem_addr_reg    <= RESET_PC_ALIGNED;
      asm_reg         <= 32'd0;
      instr_out_reg   <= 32'd0;
      instr_pc_reg    <= RESET_PC_ALIGNED;
      instr_valid_reg <= 1'b0;
    end else if (pc_load) begin
      // A redirect overrides everything else. If it coincides with a HOLD
      // handshake, the instruction counts as consumed (valid drops), but
      // the pc comes from the redirect target and not from pc+4. Clearing
      // rd_pending drops the byte that is still in flight from the old
      // stream.
      pc_reg          <= load_pc;
      byte_cnt_reg    <= 2'd0;
      rd_pending_reg  <= 1'b0;
      asm_reg         <= 32'd0;
      instr_valid_reg <= 1'b0;
      mem_addr_reg    <= load_pc;
      if (fetch_en) begin
        state_reg  <= FETCH;
        mem_rd_reg <= 1'b1;
      end else begin
        state_reg  <= IDLE;
        mem_rd_reg <= 1'b0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (fetch_en) begin
            state_reg    <= FETCH;
            byte_cnt_reg <= 2'd0;
            mem_rd_reg   <= 1'b1;
            mem_addr_reg <= pc_reg;
          end
        end

        FETCH: begin
          // FETCH lasts five cycles: four request cycles followed by one
          // drain cycle in which the last byte arrives. fetch_en is not
          // checked here, so a fetch that has started always completes.
          rd_pending_reg <= mem_rd_reg;
          if (rd_pending_reg) begin
            asm_reg <= asm_next;
          end
          if (mem_rd_reg) begin
            if (byte_cnt_reg != 2'd3) begin
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
              mem_addr_reg <= next_byte_addr;
            end else begin
              mem_rd_reg <= 1'b0;
            end
          end else if (rd_pending_reg) begin
            // Drain cycle: the fourth byte is on mem_data now.
            state_reg       <= HOLD;
            byte_cnt_reg    <= 2'd0;
            instr_out_reg   <= asm_next;
            instr_pc_reg    <= pc_reg;
            instr_valid_reg <= 1'b1;
          end else begin
            // Unreachable in normal operation. It recovers to a clean state.
            state_reg <= IDLE;
          end
        end

        HOLD: begin
          if (handshake) begin
            instr_valid_reg <= 1'b0;
            pc_reg          <= pc_plus4;
            byte_cnt_reg    <= 2'd0;
            mem_addr_reg    <= pc_plus4;
            if (fetch_en) begin
              state_reg  <= FETCH;
              mem_rd_reg <= 1'b1;
            end else begin
              state_reg  <= IDLE;
            end
          end
        end

        default: begin
          state_reg       <= IDLE;
          mem_rd_reg      <= 1'b0;
          rd_pending_reg  <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd      = mem_rd_reg;
  assign mem_addr    = mem_addr_reg;
  assign instr_out   = instr_out_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Purpose:
//   Exercises instruction_fetch_unit against a byte-wide memory model with a
//   fixed one-cycle read latency. Each expected instruction (pc and word) is
//   queued when its fetch is arranged. The queue entry is popped and compared
//   whenever the DUT completes a handshake.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_en;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [0:1023];
  logic [63:0] sb [$];

  instruction_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_en     (fetch_en),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr)
  );

  always #5 clk = ~clk;

  // Byte memory with a one-cycle read latency, indexed by the low 10 bits of
  // the address.
  always @(posedge clk) begin
    mem_data <= mem_rd ? mem[mem_addr[9:0]] : 8'h00;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Little-endian reference word starting at byte address a.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a0, a1, a2, a3;
    a0 = a;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a0[9:0]]};
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    sb.push_back({pc, word_at(pc)});
  endtask

  // Handshake monitor: the state seen at the falling edge is the state
  // that the next rising edge acts on.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("instr_pc", 64'(instr_pc), 64'(e[63:32]));
        chk("instr_out", 64'(instr_out), 64'(e[31:0]));
        $display("[TB] instr pc=%h word=%h exp_pc=%h exp_word=%h",
                 instr_pc, instr_out, e[63:32], e[31:0]);
      end
    end
  end

  // Advance to the falling edge of the next cycle in which mem_rd is high.
  task automatic wait_rd();
    @(negedge clk);
    for (int i = 0; i < 40 && !mem_rd; i++) @(negedge clk);
    chk("rd_start", 64'(mem_rd), 64'd1);
  endtask

  // Checks one complete fetch. It expects 4 request cycles at base..base+3,
  // then a drain cycle with no request, then instr_valid in cycle 5. It
  // returns at the falling edge of the first valid cycle.
  task automatic fetch_check(input logic [31:0] base);
    logic [31:0] ea;
    wait_rd();
    for (int k = 0; k < 4; k++) begin
      ea = base + 32'(k);
      chk("rd_addr", 64'(mem_addr), 64'(ea));
      chk("rd_on", 64'(mem_rd), 64'd1);
      if (k == 0) chk("valid_in_fetch", 64'(instr_valid), 64'd0);
      @(negedge clk);
    end
    chk("rd_off", 64'(mem_rd), 64'd0);
    chk("valid_early", 64'(instr_valid), 64'd0);
    @(negedge clk);
    chk("valid_lat5", 64'(instr_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;

    reset = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
    pc_load = 1'b0; pc_load_addr = '0;

    // Reset values
    #3;
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_instr_out", 64'(instr_out), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_mem_rd", 64'(mem_rd), 64'd0);

    // Basic fetch of 0x00500013 at 0, then the next one at 4
    reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
    sb.push_back({32'h0, 32'h00500013});
    push_exp(32'h4);
    fetch_check(32'h0);
    fetch_check(32'h4);

    // Backpressure on the instruction at 8
    push_exp(32'h8);
    @(posedge clk); #1 instr_ready = 1'b0;
    fetch_check(32'h8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(instr_valid), 64'd1);
      chk("bp_out", 64'(instr_out), 64'(word_at(32'h8)));
      chk("bp_pc", 64'(instr_pc), 64'h8);
      chk("bp_mem_rd", 64'(mem_rd), 64'd0);
    end
    @(posedge clk); #1 instr_ready = 1'b1; fetch_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_mem_rd", 64'(mem_rd), 64'd0);
      chk("idle_valid", 64'(instr_valid), 64'd0);
    end

    // pc advanced by 4 past the accepted instruction
    push_exp(32'hC);
    @(posedge clk); #1 fetch_en = 1'b1;
    fetch_check(32'hC);

    // Redirect to 0x103 after two bytes of the fetch at 0x10
    push_exp(32'h100);
    wait_rd();
    chk("redir_addr0", 64'(mem_addr), 64'h10);
    @(negedge clk);
    chk("redir_addr1", 64'(mem_addr), 64'h11);
    @(posedge clk); #1 pc_load = 1'b1; pc_load_addr = 32'h103;
    @(posedge clk); #1 pc_load = 1'b0;
    fetch_check(32'h100);

    // Handshake and redirect to 0x40 on the same edge
    push_exp(32'h40);
    pc_load = 1'b1; pc_load_addr = 32'h40;
    @(posedge clk); #1 pc_load = 1'b0;
    fetch_check(32'h40);

    // Wrap at the top of the address space
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    pc_load = 1'b1; pc_load_addr = 32'hFFFF_FFFE;
    @(posedge clk); #1 pc_load = 1'b0;
    fetch_check(32'hFFFF_FFFC);
    fetch_check(32'h0);

    // Asynchronous reset between edges, during the fetch at 4
    wait_rd();
    chk("ar_addr", 64'(mem_addr), 64'h4);
    #2 reset = 1'b1;
    #1;
    chk("ar_mem_rd", 64'(mem_rd), 64'd0);
    chk("ar_mem_addr", 64'(mem_addr), 64'd0);
    chk("ar_instr_out", 64'(instr_out), 64'd0);
    chk("ar_instr_pc", 64'(instr_pc), 64'd0);
    chk("ar_instr_valid", 64'(instr_valid), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    sb.push_back({32'h0, 32'h00500013});
    fetch_check(32'h0);
    fetch_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("end_mem_rd", 64'(mem_rd), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
